// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential PC, one-entry output register with valid/ready
// handshake, redirect flush, and a sticky halt on misaligned redirect targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  logic        handshake;

  assign handshake = valid_q & if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StRun: begin
        // A handshake in the redirect cycle still retires the presented entry.
        if (handshake) begin
          cnt_d = cnt_q + 32'd1;
        end
        if (redirect_en) begin
          valid_d = 1'b0;
          if (redirect_pc[1]) begin
            fault_d = 1'b1;
            state_d = StHalt;
          end else begin
            pc_d = {redirect_pc[31:2], 2'b00};
          end
        end else if (!valid_q || handshake) begin
          instr_d = imem_data;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ifpc_q  <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = ifpc_q + 32'd4;
  assign fetch_fault = fault_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table through a scoreboard queue, plus a
// separate instance checking PC wrap-around at the top of the address space.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic [31:0] imem_addr, imem_data;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4, fetch_cnt;
  logic        fetch_fault;

  logic        w_reset;
  logic [31:0] w_imem_addr, w_imem_data;
  logic        w_if_valid;
  logic [31:0] w_if_instr, w_if_pc, w_if_pc_plus4, w_fetch_cnt;
  logic        w_fetch_fault;

  int compared = 0;
  int mismatched = 0;
  int row = -1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h4) return 32'h1234_50b7;
    if (a == 32'h8) return 32'h0000_0117;
    return ~a;
  endfunction

  assign imem_data   = rom(imem_addr);
  assign w_imem_data = rom(w_imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_plus4(if_pc_plus4),
    .fetch_fault(fetch_fault),
    .fetch_cnt  (fetch_cnt)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk        (clk),
    .reset      (w_reset),
    .imem_addr  (w_imem_addr),
    .imem_data  (w_imem_data),
    .redirect_en(1'b0),
    .redirect_pc(32'h0),
    .if_valid   (w_if_valid),
    .if_ready   (1'b1),
    .if_instr   (w_if_instr),
    .if_pc      (w_if_pc),
    .if_pc_plus4(w_if_pc_plus4),
    .fetch_fault(w_fetch_fault),
    .fetch_cnt  (w_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ren;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
    logic [31:0] eaddr;
    logic        ef;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];
  vec_t sb[$];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic ren,
                              input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ecnt, input logic [31:0] eaddr,
                              input logic ef);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ren = ren; v.rpc = rpc; v.ev = ev;
    v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    reset = 1'b1; w_reset = 1'b1;
    redirect_en = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;

    //              rst  rdy  ren  rpc    ev   epc    cnt  addr   fault
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  0, 32'h0,  1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  0, 32'h0,  1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  0, 32'h4,  1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1, 32'h8,  1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  2, 32'hC,  1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  2, 32'hC,  1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  2, 32'hC,  1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  2, 32'hC,  1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  3, 32'h10, 1'b0);
    // Redirect coinciding with a handshake: counted, not re-presented.
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0,  4, 32'h18, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h18, 4, 32'h1C, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h19, 1'b0, 32'h0,  4, 32'h18, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h18, 4, 32'h1C, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h1C, 5, 32'h20, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 6, 32'h24, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h1A, 1'b0, 32'h0,  6, 32'h24, 1'b1);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0,  6, 32'h24, 1'b1);
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  6, 32'h24, 1'b1);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  0, 32'h0,  1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  0, 32'h4,  1'b0);
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1, 32'h8,  1'b0);
    vecs[21] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  2, 32'hC,  1'b0);
    vecs[22] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  3, 32'h10, 1'b0);
    vecs[23] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 4, 32'h14, 1'b0);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 4, 32'h14, 1'b0);
    vecs[25] = mk(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  0, 32'h0,  1'b0);
    vecs[26] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  0, 32'h4,  1'b0);
    vecs[27] = mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1, 32'h8,  1'b0);

    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      reset       = vecs[i].rst;
      if_ready    = vecs[i].rdy;
      redirect_en = vecs[i].ren;
      redirect_pc = vecs[i].rpc;
      sb.push_back(vecs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      row = i;
      check("if_valid", {31'b0, if_valid}, {31'b0, e.ev});
      check("imem_addr", imem_addr, e.eaddr);
      check("fetch_cnt", fetch_cnt, e.ecnt);
      check("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.ef});
      if (e.ev) begin
        check("if_pc", if_pc, e.epc);
        check("if_instr", if_instr, rom(e.epc));
        check("if_pc_plus4", if_pc_plus4, e.epc + 32'd4);
      end
      if (i == 0) begin
        check("if_instr_rst", if_instr, 32'h0);
        check("if_pc_rst", if_pc, 32'h0);
      end
    end

    // Wrap-around instance; has been held in reset so far.
    row = 100;
    reset = 1'b0; if_ready = 1'b1; redirect_en = 1'b0;
    check("w_addr_rst", w_imem_addr, 32'hFFFF_FFF8);
    check("w_valid_rst", {31'b0, w_if_valid}, 32'h0);
    w_reset = 1'b0;
    @(posedge clk); #1;
    row = 101;
    check("w_valid", {31'b0, w_if_valid}, 32'h1);
    check("w_if_pc", w_if_pc, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    row = 102;
    check("w_if_pc", w_if_pc, 32'hFFFF_FFFC);
    check("w_if_pc_plus4", w_if_pc_plus4, 32'h0);
    check("w_addr", w_imem_addr, 32'h0);
    @(posedge clk); #1;
    row = 103;
    check("w_if_pc", w_if_pc, 32'h0);
    check("w_if_instr", w_if_instr, rom(32'h0));
    check("w_fetch_cnt", w_fetch_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
